// File: rtl/char_line_renderer_pkg.sv
// char_line_renderer_pkg
// Shared constants for the character line renderer:
//   - PS/2 scancodes recognised by the keyboard FSM
//   - 3-bit glyph codes (high address bits of characterRom), including blank
//   - servo pulse-width codes per glyph
//   - keyboard FSM state encoding
package char_line_renderer_pkg;

    // PS/2 prefix and editing scancodes
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Scancodes of the printable glyph keys
    localparam logic [7:0] SC_KEY_F = 8'h2B;
    localparam logic [7:0] SC_KEY_Q = 8'h15;
    localparam logic [7:0] SC_KEY_H = 8'h33;
    localparam logic [7:0] SC_KEY_X = 8'h22;

    // Glyph codes as seen by characterRom; BLANK marks an empty slot
    localparam logic [2:0] GLYPH_F     = 3'd0;
    localparam logic [2:0] GLYPH_Q     = 3'd1;
    localparam logic [2:0] GLYPH_H     = 3'd2;
    localparam logic [2:0] GLYPH_X     = 3'd3;
    localparam logic [2:0] GLYPH_BLANK = 3'd5;

    // Servo pulse-width codes; F doubles as the reset/clear value
    localparam logic [6:0] PW_F = 7'd6;
    localparam logic [6:0] PW_Q = 7'd8;
    localparam logic [6:0] PW_H = 7'd10;
    localparam logic [6:0] PW_X = 7'd13;

    // Keyboard prefix-tracking FSM
    typedef enum logic [1:0] {
        KB_IDLE  = 2'd0,
        KB_EXT   = 2'd1,
        KB_BREAK = 2'd2
    } kb_state_e;

endpackage

// File: rtl/char_line_renderer_scan_decoder.sv
// char_line_renderer_scan_decoder (scan decoder)
// Combinational scancode -> glyph lookup.
// Ports:
//   scancode_i     PS/2 byte
//   is_glyph_o     1 when the byte is one of the printable glyph keys
//   glyph_o        glyph code (BLANK when not a glyph key)
//   pulse_width_o  servo pulse code for that glyph (F code when not a glyph)
module char_line_renderer_scan_decoder
    import char_line_renderer_pkg::*;
(
    input  logic [7:0] scancode_i,
    output logic       is_glyph_o,
    output logic [2:0] glyph_o,
    output logic [6:0] pulse_width_o
);

    // Scancode to glyph/pulse-width lookup
    always_comb begin
        is_glyph_o    = 1'b0;
        glyph_o       = GLYPH_BLANK;
        pulse_width_o = PW_F;
        case (scancode_i)
            SC_KEY_F: begin is_glyph_o = 1'b1; glyph_o = GLYPH_F; pulse_width_o = PW_F; end
            SC_KEY_Q: begin is_glyph_o = 1'b1; glyph_o = GLYPH_Q; pulse_width_o = PW_Q; end
            SC_KEY_H: begin is_glyph_o = 1'b1; glyph_o = GLYPH_H; pulse_width_o = PW_H; end
            SC_KEY_X: begin is_glyph_o = 1'b1; glyph_o = GLYPH_X; pulse_width_o = PW_X; end
            default: begin
                is_glyph_o    = 1'b0;
                glyph_o       = GLYPH_BLANK;
                pulse_width_o = PW_F;
            end
        endcase
    end

endmodule

// File: rtl/characterRom.sv
// characterRom
// Combinational 8x16 glyph bitmap ROM.
// Ports:
//   address  {glyph code[2:0], row[3:0]}
//   data     row bitmap; bit 0 is the leftmost pixel of the cell
// Codes 0..3 hold F, Q, H, X; every other code (including blank) reads 0.
module characterRom (
    input  logic [6:0] address,
    output logic [7:0] data
);

    // Bitmap lookup
    always_comb begin
        data = 8'h00;
        case (address)
            // F
            7'h01:                                           data = 8'h7E;
            7'h02, 7'h03, 7'h04, 7'h06, 7'h07, 7'h08, 7'h09: data = 8'h02;
            7'h05:                                           data = 8'h3E;
            // Q
            7'h11:                                           data = 8'h3C;
            7'h12, 7'h13, 7'h14, 7'h15, 7'h16, 7'h17:        data = 8'h42;
            7'h18:                                           data = 8'h52;
            7'h19:                                           data = 8'h22;
            7'h1A:                                           data = 8'h5C;
            // H
            7'h21, 7'h22, 7'h23, 7'h24,
            7'h26, 7'h27, 7'h28, 7'h29:                      data = 8'h42;
            7'h25:                                           data = 8'h7E;
            // X
            7'h31, 7'h36:                                    data = 8'h42;
            7'h32, 7'h35:                                    data = 8'h24;
            7'h33, 7'h34:                                    data = 8'h18;
            default:                                         data = 8'h00;
        endcase
    end

endmodule

// File: rtl/char_line_renderer.sv
// char_line_renderer
// Line editor for PS/2 glyph keys plus a scaled monochrome overlay of the line.
// Optional feature: define CURSOR_BLINK_EN for a blinking underline cursor at
// slot char_count (rows 14-15 of the cell, toggling every 32 frames).
// Ports:
//   clk          pixel/system clock
//   reset        asynchronous active-low reset
//   key_valid    one-cycle strobe qualifying scancode
//   scancode     PS/2 byte
//   x, y         current pixel column/row
//   rgbValue     all-ones on a lit pixel, else 0 (2-cycle latency from x,y)
//   pulse_width  servo code of the last appended glyph
//   char_count   glyphs in the line buffer
//   buf_full     char_count == NUM_CHARS
module char_line_renderer
    import char_line_renderer_pkg::*;
#(
    parameter int         NUM_CHARS  = 8,
    parameter int         SCALE_LOG2 = 0,
    parameter logic [9:0] LEFT       = 10'd396,
    parameter logic [9:0] TOP        = 10'd217,
    parameter int         RGB_W      = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [7:0]       scancode,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    output logic [RGB_W-1:0] rgbValue,
    output logic [6:0]       pulse_width,
    output logic [4:0]       char_count,
    output logic             buf_full
);

    // Window bounds computed in 11 bits so LEFT/TOP + extent cannot wrap
    localparam logic [10:0] X_END = {1'b0, LEFT} + 11'((NUM_CHARS * 8) << SCALE_LOG2);
    localparam logic [10:0] Y_END = {1'b0, TOP} + 11'(16 << SCALE_LOG2);

    kb_state_e              kb_state_q;
    logic [3*NUM_CHARS-1:0] slots_q;
    logic [4:0]             count_q;
    logic                   full_q;
    logic [6:0]             pw_q;

    logic       dec_is_glyph_s;
    logic [2:0] dec_glyph_s;
    logic [6:0] dec_pw_s;

    char_line_renderer_scan_decoder u_dec (
        .scancode_i   (scancode),
        .is_glyph_o   (dec_is_glyph_s),
        .glyph_o      (dec_glyph_s),
        .pulse_width_o(dec_pw_s)
    );

    // Keyboard FSM and line-buffer editing; only advances on key_valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kb_state_q <= KB_IDLE;
            slots_q    <= {NUM_CHARS{GLYPH_BLANK}};
            count_q    <= 5'd0;
            full_q     <= 1'b0;
            pw_q       <= PW_F;
        end else if (key_valid) begin
            case (kb_state_q)
                KB_IDLE: begin
                    if (scancode == SC_BREAK) begin
                        kb_state_q <= KB_BREAK;
                    end else if (scancode == SC_EXT) begin
                        kb_state_q <= KB_EXT;
                    end else begin
                        kb_state_q <= KB_IDLE;
                        if (dec_is_glyph_s) begin
                            if (!full_q) begin
                                for (int i = 0; i < NUM_CHARS; i++) begin
                                    if (count_q == 5'(i)) slots_q[3*i +: 3] <= dec_glyph_s;
                                end
                                count_q <= count_q + 5'd1;
                                full_q  <= ((count_q + 5'd1) == 5'(NUM_CHARS));
                                pw_q    <= dec_pw_s;
                            end
                        end else if (scancode == SC_BKSP) begin
                            if (count_q != 5'd0) begin
                                for (int i = 0; i < NUM_CHARS; i++) begin
                                    if (count_q == 5'(i + 1)) slots_q[3*i +: 3] <= GLYPH_BLANK;
                                end
                                count_q <= count_q - 5'd1;
                                full_q  <= 1'b0;
                            end
                        end else if (scancode == SC_ESC) begin
                            slots_q <= {NUM_CHARS{GLYPH_BLANK}};
                            count_q <= 5'd0;
                            full_q  <= 1'b0;
                            pw_q    <= PW_F;
                        end
                    end
                end
                // Extended prefix: a following F0 still starts a break sequence
                KB_EXT:   kb_state_q <= (scancode == SC_BREAK) ? KB_BREAK : KB_IDLE;
                KB_BREAK: kb_state_q <= KB_IDLE;
                default:  kb_state_q <= KB_IDLE;
            endcase
        end
    end

    logic       in_win_s;
    logic [9:0] dx_s;
    logic [9:0] dy_s;
    logic [6:0] col_s;
    logic [3:0] row_s;
    logic [3:0] slot_s;
    logic [2:0] glyph_s;

    // Stage-1 address generation: window test, cell row/column, slot glyph.
    // Outside the window the glyph is forced blank so stage 2 renders 0.
    always_comb begin
        in_win_s = ({1'b0, x} >= {1'b0, LEFT}) && ({1'b0, x} < X_END) &&
                   ({1'b0, y} >= {1'b0, TOP})  && ({1'b0, y} < Y_END);
        if (in_win_s) begin
            dx_s = x - LEFT;
            dy_s = y - TOP;
        end else begin
            dx_s = 10'd0;
            dy_s = 10'd0;
        end
        // In-window column is below 128 for any legal NUM_CHARS/SCALE_LOG2
        col_s   = 7'(dx_s >> SCALE_LOG2);
        row_s   = 4'(dy_s >> SCALE_LOG2);
        slot_s  = col_s[6:3];
        glyph_s = GLYPH_BLANK;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (in_win_s && (slot_s == 4'(i))) glyph_s = slots_q[3*i +: 3];
        end
    end

    logic [2:0] glyph_q;
    logic [3:0] row_q;
    logic [2:0] bit_q;
    logic [7:0] rom_data_s;
    logic       glyph_on_s;
    logic       pixel_s;
    logic [RGB_W-1:0] rgb_q;

`ifdef CURSOR_BLINK_EN
    logic [5:0] frame_q;
    logic       cursor_s;
    logic       cursor_q;

    // Frame counter: one tick per frame at the (0,0) pixel; bit 5 is the blink phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q <= 6'd0;
        end else if ((x == 10'd0) && (y == 10'd0)) begin
            frame_q <= frame_q + 6'd1;
        end
    end

    // Slot index < NUM_CHARS inside the window, so matching count implies count < NUM_CHARS
    assign cursor_s = in_win_s && ({1'b0, slot_s} == count_q) && (row_s >= 4'd14) && !frame_q[5];
`endif

    // Stage 1 pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glyph_q  <= 3'd0;
            row_q    <= 4'd0;
            bit_q    <= 3'd0;
`ifdef CURSOR_BLINK_EN
            cursor_q <= 1'b0;
`endif
        end else begin
            glyph_q  <= glyph_s;
            row_q    <= row_s;
            bit_q    <= col_s[2:0];
`ifdef CURSOR_BLINK_EN
            cursor_q <= cursor_s;
`endif
        end
    end

    characterRom u_rom (
        .address({glyph_q, row_q}),
        .data   (rom_data_s)
    );

    assign glyph_on_s = (glyph_q != GLYPH_BLANK) && rom_data_s[bit_q];
`ifdef CURSOR_BLINK_EN
    assign pixel_s = glyph_on_s | cursor_q;
`else
    assign pixel_s = glyph_on_s;
`endif

    // Stage 2: registered colour output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q <= {RGB_W{1'b0}};
        end else begin
            rgb_q <= {RGB_W{pixel_s}};
        end
    end

    assign rgbValue    = rgb_q;
    assign pulse_width = pw_q;
    assign char_count  = count_q;
    assign buf_full    = full_q;

endmodule

// File: tb/tb_char_line_renderer.sv
// Bench for char_line_renderer: two instances (8 glyphs unscaled, 4 glyphs at 2x)
// share the keyboard and pixel inputs. A reference model of the line buffer
// predicts register outputs; pixel expectations are queued when x,y are driven
// and popped two clocks later.
module tb_char_line_renderer;

    localparam logic [9:0] LEFT = 10'd396;
    localparam logic [9:0] TOP  = 10'd217;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd1;

    logic [8:0] rgb0, rgb1;
    logic [6:0] pw0, pw1;
    logic [4:0] cnt0, cnt1;
    logic       full0, full1;

    always #5 clk = ~clk;

    char_line_renderer dut0 (
        .clk(clk), .reset(reset), .key_valid(key_valid), .scancode(scancode),
        .x(x), .y(y), .rgbValue(rgb0), .pulse_width(pw0), .char_count(cnt0), .buf_full(full0)
    );

    char_line_renderer #(.NUM_CHARS(4), .SCALE_LOG2(1)) dut1 (
        .clk(clk), .reset(reset), .key_valid(key_valid), .scancode(scancode),
        .x(x), .y(y), .rgbValue(rgb1), .pulse_width(pw1), .char_count(cnt1), .buf_full(full1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    int m_slot [2][16];
    int m_cnt  [2];
    int m_pw   [2];
    int m_state;
    int m_frame;

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
        logic [8:0] e0;
        logic [8:0] e1;
    } pix_t;
    pix_t sb[$];
    pix_t ce;
    logic       drv_vld = 1'b0;
    logic [1:0] vld_pipe = 2'b00;

    function automatic int nc(input int d); return (d == 0) ? 8 : 4; endfunction
    function automatic int sc(input int d); return (d == 0) ? 0 : 1; endfunction

    function automatic logic [7:0] rom_row(input logic [2:0] g, input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (g)
            3'd0: case (r)
                4'd1: v = 8'h7E;  4'd5: v = 8'h3E;
                4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9: v = 8'h02;
                default: v = 8'h00;
            endcase
            3'd1: case (r)
                4'd1: v = 8'h3C;  4'd8: v = 8'h52;  4'd9: v = 8'h22;  4'd10: v = 8'h5C;
                4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: v = 8'h42;
                default: v = 8'h00;
            endcase
            3'd2: case (r)
                4'd5: v = 8'h7E;
                4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9: v = 8'h42;
                default: v = 8'h00;
            endcase
            3'd3: case (r)
                4'd1, 4'd6: v = 8'h42;  4'd2, 4'd5: v = 8'h24;  4'd3, 4'd4: v = 8'h18;
                default: v = 8'h00;
            endcase
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [8:0] exp_pix(input int d, input logic [9:0] px, input logic [9:0] py);
        int dx, dy, col, row, slot, b;
        logic [7:0] bits;
        logic on;
        dx = int'(px) - int'(LEFT);
        dy = int'(py) - int'(TOP);
        on = 1'b0;
        if (dx >= 0 && dx < ((nc(d) * 8) << sc(d)) && dy >= 0 && dy < (16 << sc(d))) begin
            col  = dx >> sc(d);
            row  = dy >> sc(d);
            slot = col / 8;
            b    = col % 8;
            if (m_slot[d][slot] != 5) begin
                bits = rom_row(3'(m_slot[d][slot]), 4'(row));
                on = bits[b];
            end
`ifdef CURSOR_BLINK_EN
            if (slot == m_cnt[d] && row >= 14 && (m_frame % 64) < 32) on = 1'b1;
`endif
        end
        return on ? 9'h1FF : 9'h000;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) m_slot[d][k] = 5;
            m_cnt[d] = 0;
            m_pw[d]  = 6;
        end
        m_state = 0;
        m_frame = 0;
    endfunction

    function automatic void model_key(input logic [7:0] s);
        int g, p;
        g = -1;
        p = 0;
        case (m_state)
            0: begin
                if (s == 8'hF0) m_state = 2;
                else if (s == 8'hE0) m_state = 1;
                else begin
                    case (s)
                        8'h2B: begin g = 0; p = 6;  end
                        8'h15: begin g = 1; p = 8;  end
                        8'h33: begin g = 2; p = 10; end
                        8'h22: begin g = 3; p = 13; end
                        default: g = -1;
                    endcase
                    for (int d = 0; d < 2; d++) begin
                        if (g >= 0) begin
                            if (m_cnt[d] < nc(d)) begin
                                m_slot[d][m_cnt[d]] = g;
                                m_cnt[d] = m_cnt[d] + 1;
                                m_pw[d] = p;
                            end
                        end else if (s == 8'h66) begin
                            if (m_cnt[d] > 0) begin
                                m_cnt[d] = m_cnt[d] - 1;
                                m_slot[d][m_cnt[d]] = 5;
                            end
                        end else if (s == 8'h76) begin
                            for (int k = 0; k < 16; k++) m_slot[d][k] = 5;
                            m_cnt[d] = 0;
                            m_pw[d]  = 6;
                        end
                    end
                end
            end
            1: m_state = (s == 8'hF0) ? 2 : 0;
            default: m_state = 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    // One clock of stimulus; expectations come from the model before the key updates it
    task automatic step(input logic kv, input logic [7:0] s, input logic pv,
                        input logic [9:0] px, input logic [9:0] py);
        pix_t e;
        @(posedge clk);
        #1;
        if (pv) begin
            e.px = px; e.py = py;
            e.e0 = exp_pix(0, px, py);
            e.e1 = exp_pix(1, px, py);
            sb.push_back(e);
        end
        if (px == 10'd0 && py == 10'd0 && reset) m_frame++;
        if (kv && reset) model_key(s);
        key_valid = kv;
        scancode  = s;
        x         = px;
        y         = py;
        drv_vld   = pv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 10'd0, 10'd1);
    endtask

    task automatic send(input logic [7:0] s);
        step(1'b1, s, 1'b0, 10'd0, 10'd1);
        idle(1);
    endtask

    task automatic pix(input logic [9:0] px, input logic [9:0] py);
        step(1'b0, 8'h00, 1'b1, px, py);
    endtask

    task automatic check_regs(input string tag);
        @(negedge clk);
        chk({tag, "_cnt0"},  32'(cnt0),  32'(m_cnt[0]));
        chk({tag, "_cnt1"},  32'(cnt1),  32'(m_cnt[1]));
        chk({tag, "_pw0"},   32'(pw0),   32'(m_pw[0]));
        chk({tag, "_pw1"},   32'(pw1),   32'(m_pw[1]));
        chk({tag, "_full0"}, 32'(full0), 32'(m_cnt[0] == 8));
        chk({tag, "_full1"}, 32'(full1), 32'(m_cnt[1] == 4));
    endtask

    // Pixel scoreboard: output appears two rising edges after x,y are driven
    always @(posedge clk) vld_pipe <= {vld_pipe[0], drv_vld};

    always @(negedge clk) begin
        if (vld_pipe[1]) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                ce = sb.pop_front();
                chk($sformatf("pix0_x%0d_y%0d", ce.px, ce.py), 32'(rgb0), 32'(ce.e0));
                chk($sformatf("pix1_x%0d_y%0d", ce.px, ce.py), 32'(rgb1), 32'(ce.e1));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_regs("reset");
        chk("reset_rgb0", 32'(rgb0), 32'd0);
        chk("reset_rgb1", 32'(rgb1), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        // Empty line renders nothing
        pix(LEFT, TOP + 10'd2);
        idle(1);

        // Type F, Q
        send(8'h2B);
        send(8'h15);
        check_regs("type_fq");

        // Back-to-back pixels down column 1, including rows past the unscaled window
        for (int r = 0; r < 18; r++) pix(LEFT + 10'd1, TOP + 10'(r));
        for (int b = 0; b < 8; b++) pix(LEFT + 10'd8 + 10'(b), TOP + 10'd5);
        // Scaled instance: offsets 2 and 3 map to the same bit
        pix(LEFT + 10'd2, TOP + 10'd4);
        pix(LEFT + 10'd3, TOP + 10'd4);
        pix(LEFT + 10'd0, TOP + 10'd2);
        pix(LEFT + 10'd1, TOP + 10'd2);
        // Window edges
        pix(LEFT - 10'd1, TOP + 10'd2);
        pix(LEFT + 10'd1, TOP - 10'd1);
        pix(LEFT + 10'd63, TOP + 10'd2);
        pix(LEFT + 10'd64, TOP + 10'd2);
        pix(LEFT + 10'd127, TOP + 10'd2);
        pix(LEFT + 10'd128, TOP + 10'd2);
        pix(LEFT + 10'd1, TOP + 10'd31);
        pix(LEFT + 10'd1, TOP + 10'd32);
        idle(1);

        // Break and extended prefixes swallow the following byte
        send(8'hF0); send(8'h2B);
        send(8'hE0); send(8'hF0); send(8'h15);
        send(8'hE0); send(8'h33);
        check_regs("prefix_drop");

        // Fill the 4-glyph instance; its last key is ignored
        send(8'h33); send(8'h22); send(8'h2B);
        check_regs("fill4");
        send(8'h2B);
        pix(LEFT + 10'd50, TOP + 10'd2);
        idle(1);
        send(8'h66);
        check_regs("bksp");
        pix(LEFT + 10'd50, TOP + 10'd2);
        idle(1);

        // Write and read the same slot in one cycle: pre-write glyph is shown
        step(1'b1, 8'h33, 1'b1, LEFT + 10'd41, TOP + 10'd5);
        pix(LEFT + 10'd41, TOP + 10'd5);
        idle(1);
        check_regs("same_cycle");

        // key_valid on consecutive cycles
        step(1'b1, 8'h66, 1'b0, 10'd0, 10'd1);
        step(1'b1, 8'h66, 1'b0, 10'd0, 10'd1);
        step(1'b1, 8'h15, 1'b0, 10'd0, 10'd1);
        idle(1);
        check_regs("burst");
        step(1'b1, 8'hF0, 1'b0, 10'd0, 10'd1);
        step(1'b1, 8'h22, 1'b0, 10'd0, 10'd1);
        step(1'b1, 8'h22, 1'b0, 10'd0, 10'd1);
        idle(1);
        check_regs("burst_break");

        // Fill the 8-glyph instance, then overflow and clear
        for (int k = 0; k < 8; k++) begin
            if (m_cnt[0] < 8) send(8'h22);
        end
        send(8'h15);
        check_regs("full8");
        for (int k = 0; k < 8; k++) pix(LEFT + 10'(8 * k + 1), TOP + 10'd1);
        idle(1);
        send(8'h76);
        check_regs("esc");
        for (int k = 0; k < 16; k++) pix(LEFT + 10'(8 * k + 1), TOP + 10'(2 + (k % 4)));
        idle(1);

        // Reset in the middle of a break sequence with a lit pixel on the inputs
        send(8'h2B);
        pix(LEFT + 10'd1, TOP + 10'd2);
        step(1'b1, 8'hF0, 1'b0, 10'd0, 10'd1);
        idle(2);
        #2;
        reset = 1'b0;
        x = LEFT + 10'd1;
        y = TOP + 10'd2;
        model_reset();
        check_regs("midreset");
        chk("midreset_rgb0", 32'(rgb0), 32'd0);
        chk("midreset_rgb1", 32'(rgb1), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("midreset_hold_rgb0", 32'(rgb0), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        x = 10'd0;
        y = 10'd1;
        send(8'h15);
        check_regs("after_reset");

        // Cursor rows at slot char_count, then again after 32 frame ticks
        pix(LEFT + 10'd11, TOP + 10'd14);
        pix(LEFT + 10'd20, TOP + 10'd29);
        pix(LEFT + 10'd11, TOP + 10'd15);
        idle(1);
        for (int f = 0; f < 32; f++) step(1'b0, 8'h00, 1'b0, 10'd0, 10'd0);
        idle(1);
        pix(LEFT + 10'd11, TOP + 10'd14);
        pix(LEFT + 10'd20, TOP + 10'd29);
        idle(4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/char_line_renderer.md
# char_line_renderer

Multi-character successor to the single-glyph character register. Accepts PS/2 scancodes from the keyboard receiver, maintains a line buffer of up to NUM_CHARS glyphs with append, backspace and clear editing, and renders the line as a scaled monochrome overlay in the VGA pixel stream. It sits between the PS/2 receiver and the VGA colour mux, and also drives the servo pulse-width code of the most recently typed character.

## Interface
- NUM_CHARS, 8: line buffer depth in glyphs (1..16).
- SCALE_LOG2, 0: glyph magnification, 2^SCALE_LOG2 per axis (0..2).
- LEFT, 10'd396: x of first glyph's left edge.
- TOP, 10'd217: y of glyph top edge.
- RGB_W, 9: colour output width.

- clk  in  1  pixel/system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- key_valid  in  1  one-cycle strobe, scancode valid.
- scancode  in  8  PS/2 byte.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- rgbValue  out  RGB_W  all-ones (glyph pixel) or all-zeros.
- pulse_width  out  7  servo pulse code of last appended glyph.
- char_count  out  5  glyphs currently in buffer.
- buf_full  out  1  char_count == NUM_CHARS.

## Operation
- Glyph codes (3 bit, characterRom high address): 2b→0 (F, pw 6), 15→1 (Q, pw 8), 33→2 (H, pw 10), 22→3 (X, pw 13); empty slot = 5 (blank).
- Keyboard FSM, advances only on key_valid: IDLE: F0→BREAK, E0→EXT, else process byte, stay IDLE. EXT: F0→BREAK, any other byte dropped→IDLE. BREAK: any byte dropped→IDLE.
- Processing in IDLE: glyph key → write slot[char_count], char_count+1, pulse_width updated; ignored when buf_full (no write, pulse_width unchanged). 66 (backspace) → if char_count>0, slot[char_count-1]=blank, char_count-1; at 0 no effect; pulse_width unchanged. 76 (Esc) → all slots blank, char_count=0, pulse_width=6. Other bytes ignored.
- Render window: x in [LEFT, LEFT+NUM_CHARS·8·2^S), y in [TOP, TOP+16·2^S). Inside: col=(x-LEFT)>>S, row=(y-TOP)>>S; slot=col[..:3], bit=col[2:0]; ROM address {slot glyph, row[3:0]}; pixel = row_data[bit]. Outside window or blank slot: 0. Subtractions 10-bit unsigned, evaluated only inside window.
- Reset: all slots blank, char_count 0, FSM IDLE, pulse_width 6, rgbValue 0, pipeline registers 0.

## Timing
- Pixel path two-stage: stage 1 registers in-window flag, glyph code, row, bit; ROM combinational from stage 1; stage 2 registers rgbValue. x,y→rgbValue latency exactly 2 cycles; throughput one pixel per cycle.
- Key processing: buffer, char_count, buf_full, pulse_width update on the clk edge sampling key_valid; visible to stage 1 next cycle.
- Key write and pixel read of same slot in same cycle: stage 1 captures pre-write glyph.
- key_valid on consecutive cycles: each byte processed in order, no drops.
- reset asserted mid-frame or mid-sequence (e.g. after F0): immediate return to reset state; next byte handled in IDLE.

## Configuration
- CURSOR_BLINK_EN defined: underline cursor at slot char_count (rows 14–15 of cell, all 8 bits) when char_count<NUM_CHARS; toggles every 32 frames via frame counter incremented when x==0,y==0; counter reset 0, cursor visible first. Rendered through same 2-cycle pipeline, OR'd with glyph pixel.
- Not defined: no cursor, no frame counter; slot char_count renders blank.

## Structure
- Shared package/include (parameters.v): scancode constants (F0, E0, 66, 76, glyph keys), glyph code constants incl. blank, pulse-width constants, FSM state encodings.
- Sub-module scan_decoder: combinational scancode→{is_glyph, glyph code, pulse width}; characterRom reused unchanged.

## Test plan
- Reset, then type 2b,15 → char_count 2, pulse_width 8; pixel at (LEFT,TOP+r) matches ROM {0,r}[0] two cycles later.
- Send F0,2b → both dropped, char_count unchanged; E0,F0,15 → dropped.
- NUM_CHARS=4: five glyph keys → char_count 4, buf_full 1, fifth ignored; 66 → char_count 3, slot 3 renders 0.
- 76 with full buffer → char_count 0, pulse_width 6, whole window renders 0.
- SCALE_LOG2=1: x=LEFT+1 and LEFT+0 render same bit; x=LEFT+16·NUM_CHARS → 0.
- reset low during F0 sequence and mid-line → outputs at reset values; with CURSOR_BLINK_EN cursor visible at slot 0, toggles after 32 frames.
